// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode and ID/EX pipeline register.
// Forwards same-cycle writeback, refreshes held operands, inserts load-use bubbles.
module id_ex_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  read_reg1,
    output logic [4:0]  read_reg2,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        flush,
    input  logic        hold,
    output logic        load_use_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_alu_src,
    output logic        ex_illegal
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        illegal;
    } id_ex_t;

    id_ex_t      ex_q;
    id_ex_t      ex_d;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        refresh1;
    logic        refresh2;

    assign opcode    = if_instr[6:0];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign rd        = if_instr[11:7];
    assign read_reg1 = rs1;
    assign read_reg2 = rs2;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};

    function automatic logic [31:0] operand(input logic [4:0]  idx,
                                            input logic [31:0] rf);
        if (idx == 5'd0)
            return '0;
        if (BYPASS_EN && wb_reg_write && wb_write_reg == idx)
            return wb_write_data;
        return rf;
    endfunction

    always_comb begin
        ex_d          = '0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        ex_d.valid    = if_valid;
        ex_d.pc       = if_pc;
        ex_d.rs1      = rs1;
        ex_d.rs2      = rs2;
        ex_d.rd       = rd;
        ex_d.opcode   = opcode;
        ex_d.funct3   = if_instr[14:12];
        ex_d.funct7b5 = if_instr[30];
        ex_d.rs1_data = operand(rs1, read_data1);
        ex_d.rs2_data = operand(rs2, read_data2);
        unique case (1'b1)
            opcode == OP_R: begin
                ex_d.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            opcode == OP_IMM, opcode == OP_JALR: begin
                ex_d.reg_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                ex_d.imm       = imm_i;
                uses_rs1       = 1'b1;
            end
            opcode == OP_LOAD: begin
                ex_d.reg_write = 1'b1;
                ex_d.mem_read  = 1'b1;
                ex_d.alu_src   = 1'b1;
                ex_d.imm       = imm_i;
                uses_rs1       = 1'b1;
            end
            opcode == OP_STORE: begin
                ex_d.mem_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                ex_d.imm       = imm_s;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            opcode == OP_BRANCH: begin
                ex_d.branch = 1'b1;
                ex_d.imm    = imm_b;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            opcode == OP_JAL: begin
                ex_d.reg_write = 1'b1;
                ex_d.imm       = imm_j;
            end
            opcode == OP_LUI, opcode == OP_AUIPC: begin
                ex_d.reg_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                ex_d.imm       = imm_u;
            end
            default: ex_d.illegal = 1'b1;
        endcase
        ex_d.reg_write = ex_d.reg_write & (rd != 5'd0);
    end

    assign load_use_stall = if_valid & ex_q.valid & ex_q.mem_read
                          & (ex_q.rd != 5'd0)
                          & ((uses_rs1 & (rs1 == ex_q.rd))
                           | (uses_rs2 & (rs2 == ex_q.rd)))
                          & ~flush;

    // A held instruction must still observe writebacks to its sources.
    assign refresh1 = ex_q.valid & wb_reg_write & (wb_write_reg != 5'd0)
                    & (wb_write_reg == ex_q.rs1);
    assign refresh2 = ex_q.valid & wb_reg_write & (wb_write_reg != 5'd0)
                    & (wb_write_reg == ex_q.rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (flush || (!hold && load_use_stall)) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
            ex_q.branch    <= 1'b0;
            ex_q.alu_src   <= 1'b0;
            ex_q.illegal   <= 1'b0;
        end else if (hold) begin
            if (refresh1)
                ex_q.rs1_data <= wb_write_data;
            if (refresh2)
                ex_q.rs2_data <= wb_write_data;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct3    = ex_q.funct3;
    assign ex_funct7b5  = ex_q.funct7b5;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_branch    = ex_q.branch;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage, bypass on (u0) and off (u1).
// Directed plan cases followed by randomized traffic against a reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic [31:0] read_data1 = '0;
    logic [31:0] read_data2 = '0;
    logic [31:0] wb_write_data = '0;
    logic [4:0]  wb_write_reg = '0;

    logic [4:0]  w_rr1 [2];
    logic [4:0]  w_rr2 [2];
    logic        w_stall [2];
    logic        w_valid [2];
    logic [31:0] w_pc [2];
    logic [31:0] w_imm [2];
    logic [31:0] w_d1 [2];
    logic [31:0] w_d2 [2];
    logic [4:0]  w_rs1 [2];
    logic [4:0]  w_rs2 [2];
    logic [4:0]  w_rd [2];
    logic [6:0]  w_op [2];
    logic [2:0]  w_f3 [2];
    logic        w_f7 [2];
    logic        w_rw [2];
    logic        w_mr [2];
    logic        w_mw [2];
    logic        w_br [2];
    logic        w_as [2];
    logic        w_ill [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_ex_stage #(.BYPASS_EN(g == 0 ? 1'b1 : 1'b0)) u (
            .clk(clk), .reset(reset),
            .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
            .read_reg1(w_rr1[g]), .read_reg2(w_rr2[g]),
            .read_data1(read_data1), .read_data2(read_data2),
            .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
            .wb_write_data(wb_write_data),
            .flush(flush), .hold(hold), .load_use_stall(w_stall[g]),
            .ex_valid(w_valid[g]), .ex_pc(w_pc[g]), .ex_imm(w_imm[g]),
            .ex_rs1_data(w_d1[g]), .ex_rs2_data(w_d2[g]),
            .ex_rs1(w_rs1[g]), .ex_rs2(w_rs2[g]), .ex_rd(w_rd[g]),
            .ex_opcode(w_op[g]), .ex_funct3(w_f3[g]), .ex_funct7b5(w_f7[g]),
            .ex_reg_write(w_rw[g]), .ex_mem_read(w_mr[g]),
            .ex_mem_write(w_mw[g]), .ex_branch(w_br[g]),
            .ex_alu_src(w_as[g]), .ex_illegal(w_ill[g])
        );
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw, br, as, ill;
        logic        partial;
    } st_t;

    st_t mdl [2];
    st_t q0 [$];
    st_t q1 [$];
    int  passed = 0;
    int  total = 0;

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s u%0d act=%h exp=%h t=%0t", nm, k, act, exp, $time);
    endtask

    // {reg_write, mem_read, mem_write, branch, alu_src, uses_rs1, uses_rs2}
    function automatic logic [6:0] ctl_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 7'b1000011;
            7'b0010011: return 7'b1000110;
            7'b0000011: return 7'b1100110;
            7'b0100011: return 7'b0010111;
            7'b1100011: return 7'b0001011;
            7'b1101111: return 7'b1000000;
            7'b1100111: return 7'b1000110;
            7'b0110111: return 7'b1000100;
            7'b0010111: return 7'b1000100;
            default:    return 7'b0000000;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        int s;
        s = int'(i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                return 32'(s >>> 20);
            7'b0100011:
                return 32'((s >>> 25) * 32 + int'(i[11:7]));
            7'b1100011:
                return 32'((s >>> 31) * 4096 + int'(i[7]) * 2048
                           + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
            7'b1101111:
                return 32'((s >>> 31) * 1048576 + int'(i[19:12]) * 4096
                           + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
            7'b0110111, 7'b0010111:
                return i & 32'hFFFFF000;
            default:
                return 32'h0;
        endcase
    endfunction

    function automatic logic stall_of(input st_t s);
        logic [6:0] c;
        logic [4:0] a, b;
        c = ctl_of(if_instr[6:0]);
        a = if_instr[19:15];
        b = if_instr[24:20];
        return if_valid && s.valid && s.mr && s.rd != 0 && !flush &&
               ((c[1] && a == s.rd) || (c[0] && b == s.rd));
    endfunction

    function automatic logic [31:0] pick(input logic [4:0] idx,
                                         input logic [31:0] rf, input bit byp);
        if (idx == 0) return 32'h0;
        if (byp && wb_reg_write && wb_write_reg == idx) return wb_write_data;
        return rf;
    endfunction

    function automatic st_t nxt(input st_t s, input bit byp, input logic stl);
        st_t n;
        logic [6:0] c;
        n = s;
        if (reset) begin
            n = '{default: 0};
        end else if (flush || (!hold && stl)) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
            n.br = 0; n.as = 0; n.ill = 0; n.partial = 1;
        end else if (hold) begin
            if (s.valid && wb_reg_write && wb_write_reg != 0) begin
                if (wb_write_reg == s.rs1) n.d1 = wb_write_data;
                if (wb_write_reg == s.rs2) n.d2 = wb_write_data;
            end
        end else begin
            c = ctl_of(if_instr[6:0]);
            n.valid = if_valid;
            n.pc = if_pc;
            n.imm = imm_of(if_instr);
            n.rs1 = if_instr[19:15];
            n.rs2 = if_instr[24:20];
            n.rd = if_instr[11:7];
            n.op = if_instr[6:0];
            n.f3 = if_instr[14:12];
            n.f7 = if_instr[30];
            n.d1 = pick(n.rs1, read_data1, byp);
            n.d2 = pick(n.rs2, read_data2, byp);
            n.rw = c[6] && n.rd != 0;
            n.mr = c[5]; n.mw = c[4]; n.br = c[3]; n.as = c[2];
            n.ill = (c == 0);
            n.partial = 0;
        end
        return n;
    endfunction

    task automatic step(input logic r, f, h, v, input logic [31:0] ins, pc,
                        input logic [31:0] d1, d2, input logic w,
                        input logic [4:0] wr, input logic [31:0] wd);
        logic s;
        @(negedge clk);
        reset = r; flush = f; hold = h; if_valid = v;
        if_instr = ins; if_pc = pc; read_data1 = d1; read_data2 = d2;
        wb_reg_write = w; wb_write_reg = wr; wb_write_data = wd;
        #1;
        for (int k = 0; k < 2; k++) begin
            s = stall_of(mdl[k]);
            chk("read_reg1", k, 32'(w_rr1[k]), 32'(ins[19:15]));
            chk("read_reg2", k, 32'(w_rr2[k]), 32'(ins[24:20]));
            chk("load_use_stall", k, 32'(w_stall[k]), 32'(s));
            mdl[k] = nxt(mdl[k], k == 0, s);
        end
        q0.push_back(mdl[0]);
        q1.push_back(mdl[1]);
    endtask

    task automatic cmp(input int k, input st_t e);
        chk("ex_valid", k, 32'(w_valid[k]), 32'(e.valid));
        chk("ex_reg_write", k, 32'(w_rw[k]), 32'(e.rw));
        chk("ex_mem_read", k, 32'(w_mr[k]), 32'(e.mr));
        chk("ex_mem_write", k, 32'(w_mw[k]), 32'(e.mw));
        chk("ex_branch", k, 32'(w_br[k]), 32'(e.br));
        chk("ex_alu_src", k, 32'(w_as[k]), 32'(e.as));
        if (!e.partial) begin
            chk("ex_illegal", k, 32'(w_ill[k]), 32'(e.ill));
            chk("ex_pc", k, w_pc[k], e.pc);
            chk("ex_imm", k, w_imm[k], e.imm);
            chk("ex_rs1_data", k, w_d1[k], e.d1);
            chk("ex_rs2_data", k, w_d2[k], e.d2);
            chk("ex_rs1", k, 32'(w_rs1[k]), 32'(e.rs1));
            chk("ex_rs2", k, 32'(w_rs2[k]), 32'(e.rs2));
            chk("ex_rd", k, 32'(w_rd[k]), 32'(e.rd));
            chk("ex_opcode", k, 32'(w_op[k]), 32'(e.op));
            chk("ex_funct3", k, 32'(w_f3[k]), 32'(e.f3));
            chk("ex_funct7b5", k, 32'(w_f7[k]), 32'(e.f7));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) cmp(0, q0.pop_front());
            if (q1.size() > 0) cmp(1, q1.pop_front());
        end
    end

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h0080A283;
    localparam logic [31:0] ADD2 = 32'h00228333;
    localparam logic [31:0] BEQ  = 32'hFE208EE3;
    localparam logic [31:0] SW   = 32'hFE20AA23;

    initial begin
        logic [31:0] ins;
        logic [6:0]  op;
        mdl[0] = '{default: 0};
        mdl[1] = '{default: 0};
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, ADD, 32'h10, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, ADD, 32'h14, 1, 2, 1, 2, 32'hDEADBEEF);
        step(0, 0, 0, 1, LW, 32'h18, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, ADD2, 32'h1C, 7, 2, 0, 0, 0);
        step(0, 0, 0, 1, ADD2, 32'h1C, 7, 2, 0, 0, 0);
        step(0, 0, 0, 1, BEQ, 32'h20, 3, 4, 0, 0, 0);
        step(0, 0, 0, 1, SW, 32'h24, 3, 4, 0, 0, 0);
        step(0, 0, 0, 1, ADD, 32'h28, 1, 2, 0, 0, 0);
        step(0, 0, 1, 1, SW, 32'h2C, 9, 9, 1, 1, 32'h55);
        step(0, 0, 1, 1, SW, 32'h2C, 9, 9, 1, 0, 32'h77);
        step(0, 0, 0, 1, LW, 32'h30, 1, 2, 0, 0, 0);
        step(0, 1, 1, 1, ADD2, 32'h34, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, ADD, 32'h38, 1, 2, 0, 0, 0);
        step(1, 0, 1, 1, ADD, 32'h3C, 1, 2, 1, 1, 32'h99);
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                6: op = 7'b1100111;
                7: op = 7'b0110111;
                8: op = 7'b0010111;
                default: op = 7'($urandom);
            endcase
            ins = $urandom;
            ins[6:0] = op;
            ins[11:7] = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 85,
                 ins, $urandom, $urandom, $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)),
                 $urandom);
        end
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drain", 0, 32'(q0.size() + q1.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
